// File: rtl/io_read_arbiter.sv
// I/O read data arbiter: grants the CPU read bus to the highest-priority responder
// for one bus cycle, with hold timeout, collision pulse and saturating collision count.
module io_read_arbiter #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ioreq,
  input  logic       rd,
  input  logic [3:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  output logic [7:0] d_out,
  output logic       d_out_active,
  output logic [1:0] owner,
  output logic       collision,
  output logic [7:0] collision_cnt,
  output logic       timeout
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REQ_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    hold_cnt, hold_cnt_nxt, hold_inc;
  logic [DATA_W-1:0]   d_out_nxt;
  logic                d_out_active_nxt;
  logic [IDX_W-1:0]    owner_nxt, prio_idx;
  logic                collision_nxt, timeout_nxt, multi_req, cyc;
  logic [DATA_W-1:0]   collision_cnt_nxt;
  logic [DATA_W-1:0]   data_arr [REQ_W];

  assign cyc         = ioreq & rd;
  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;
  assign data_arr[3] = data3;
  assign hold_inc    = hold_cnt + CNT_W'(1);
  assign multi_req   = (req & (req - REQ_W'(1))) != REQ_W'(0);

  // Fixed priority: bit 0 wins
  always_comb begin
    if (req[0])      prio_idx = IDX_W'(0);
    else if (req[1]) prio_idx = IDX_W'(1);
    else if (req[2]) prio_idx = IDX_W'(2);
    else             prio_idx = IDX_W'(3);
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt         = state;
    hold_cnt_nxt      = hold_cnt;
    d_out_nxt         = d_out;
    d_out_active_nxt  = 1'b0;
    owner_nxt         = owner;
    collision_nxt     = 1'b0;
    collision_cnt_nxt = collision_cnt;
    timeout_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cyc && (req != REQ_W'(0))) begin
          state_nxt        = ST_GRANT;
          owner_nxt        = prio_idx;
          d_out_nxt        = data_arr[prio_idx];
          d_out_active_nxt = 1'b1;
          hold_cnt_nxt     = CNT_W'(0);
          collision_nxt    = multi_req;
          if (multi_req && !(&collision_cnt))
            collision_cnt_nxt = collision_cnt + DATA_W'(1);
        end
      end
      ST_GRANT: begin
        // Strobe release wins over responder drop and timeout
        if (!cyc) begin
          state_nxt = ST_IDLE;
        end else if (!req[owner]) begin
          state_nxt = ST_DONE;
        end else if (hold_inc == CNT_W'(TIMEOUT)) begin
          state_nxt    = ST_DONE;
          timeout_nxt  = 1'b1;
          hold_cnt_nxt = hold_inc;
        end else begin
          d_out_active_nxt = 1'b1;
          d_out_nxt        = data_arr[owner];
          hold_cnt_nxt     = hold_inc;
        end
      end
      ST_DONE: begin
        if (!cyc) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state         <= ST_IDLE;
      hold_cnt      <= CNT_W'(0);
      d_out         <= 8'hFF;
      d_out_active  <= 1'b0;
      owner         <= IDX_W'(0);
      collision     <= 1'b0;
      collision_cnt <= DATA_W'(0);
      timeout       <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_cnt_nxt;
      d_out         <= d_out_nxt;
      d_out_active  <= d_out_active_nxt;
      owner         <= owner_nxt;
      collision     <= collision_nxt;
      collision_cnt <= collision_cnt_nxt;
      timeout       <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_io_read_arbiter.sv
// Randomized and directed bench for io_read_arbiter against a bus-cycle level model.
module tb_io_read_arbiter;

  localparam int unsigned TO = 4;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       ioreq = 1'b0;
  logic       rd = 1'b0;
  logic [3:0] req = 4'd0;
  logic [7:0] data [4];
  logic [7:0] d_out;
  logic       d_out_active;
  logic [1:0] owner;
  logic       collision;
  logic [7:0] collision_cnt;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Model: a read transfer is either live (driving), finished but waiting for
  // strobe release, or absent.
  bit         m_live, m_wait_release, m_coll, m_to;
  int         m_age;
  logic [1:0] m_owner;
  logic [7:0] m_dout;
  int         m_cnt;

  io_read_arbiter #(.TIMEOUT(TO)) dut (
    .clk28(clk28), .rst(rst), .ioreq(ioreq), .rd(rd), .req(req),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .d_out(d_out), .d_out_active(d_out_active), .owner(owner),
    .collision(collision), .collision_cnt(collision_cnt), .timeout(timeout)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit cyc;
    cyc = ioreq && rd;
    m_coll = 0;
    m_to = 0;
    if (rst) begin
      m_live = 0; m_wait_release = 0; m_age = 0;
      m_owner = 2'd0; m_dout = 8'hFF; m_cnt = 0;
    end else if (m_live) begin
      if (!cyc) m_live = 0;
      else if (!req[m_owner]) begin m_live = 0; m_wait_release = 1; end
      else if (m_age == int'(TO)) begin m_live = 0; m_wait_release = 1; m_to = 1; end
      else begin m_age++; m_dout = data[m_owner]; end
    end else if (m_wait_release) begin
      if (!cyc) m_wait_release = 0;
    end else if (cyc && req != 4'd0) begin
      for (int i = 3; i >= 0; i--) if (req[i]) m_owner = 2'(i);
      m_dout = data[m_owner];
      m_live = 1;
      m_age  = 1;
      if ($countones(req) >= 2) begin
        m_coll = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk28);
    model_edge();
    @(negedge clk28);
    chk("d_out", 32'(d_out), 32'(m_dout));
    chk("d_out_active", 32'(d_out_active), 32'(m_live));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("collision", 32'(collision), 32'(m_coll));
    chk("collision_cnt", 32'(collision_cnt), 32'(m_cnt));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic bus(input logic c, input logic [3:0] r);
    ioreq = c;
    rd    = c;
    req   = r;
  endtask

  initial begin
    int act, tos;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    step();
    step();
    chk("reset_dout", 32'(d_out), 32'hFF);
    rst = 1'b0;
    step();

    // single responder
    data[1] = 8'h1F;
    bus(1'b1, 4'b0010);
    step();
    chk("single_dout", 32'(d_out), 32'h1F);
    chk("single_owner", 32'(owner), 32'd1);
    bus(1'b0, 4'b0000);
    step();

    // collision between 0 and 2
    data[0] = 8'hBF;
    data[2] = 8'h3C;
    bus(1'b1, 4'b0101);
    step();
    chk("coll_dout", 32'(d_out), 32'hBF);
    chk("coll_pulse", 32'(collision), 32'd1);
    step();
    chk("coll_pulse_end", 32'(collision), 32'd0);
    bus(1'b0, 4'b0000);
    step();

    // no preemption, then responder drop locks until strobe release
    bus(1'b1, 4'b0100);
    step();
    req = 4'b0101;
    step();
    chk("no_preempt", 32'(owner), 32'd2);
    req = 4'b0001;
    step();
    chk("drop_inactive", 32'(d_out_active), 32'd0);
    step();
    chk("done_no_regrant", 32'(d_out_active), 32'd0);
    bus(1'b0, 4'b0000);
    step();

    // timeout after TO active cycles
    act = 0;
    tos = 0;
    bus(1'b1, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      step();
      act += int'(d_out_active);
      tos += int'(timeout);
    end
    chk("to_active_cycles", 32'(act), 32'(TO));
    chk("to_pulses", 32'(tos), 32'd1);
    bus(1'b0, 4'b0000);
    step();

    // saturation of collision counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      bus(1'b1, 4'b0011);
      step();
      bus(1'b0, 4'b0000);
      step();
    end
    chk("sat_256", 32'(collision_cnt), 32'd255);
    bus(1'b1, 4'b1100);
    step();
    chk("sat_257", 32'(collision_cnt), 32'd255);
    bus(1'b0, 4'b0000);
    step();

    // reset in the middle of a grant, then fresh grant
    data[3] = 8'h5A;
    bus(1'b1, 4'b1000);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_active", 32'(d_out_active), 32'd0);
    chk("rst_mid_dout", 32'(d_out), 32'hFF);
    rst = 1'b0;
    step();
    chk("regrant_owner", 32'(owner), 32'd3);
    chk("regrant_active", 32'(d_out_active), 32'd1);
    bus(1'b0, 4'b0000);
    step();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ioreq = ($urandom_range(0, 3) != 0);
        rd    = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
